// File: rtl/wb_trace_pkg.sv
// Shared types and helpers for the write-back trace buffer.
package wb_trace_pkg;

  localparam int unsigned TRACE_DATA_W = 32;
  localparam int unsigned TRACE_REG_AW = 5;
  localparam int unsigned TRACE_TS_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    POST,
    FROZEN
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_REG_AW-1:0] rgi;
    logic [TRACE_DATA_W-1:0] data;
    logic [TRACE_DATA_W-1:0] pc;
    logic [TRACE_TS_W-1:0]   ts;
  } trace_entry_t;

  // Rotate the low w bits of v left by one; bits above w are cleared.
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << 1) | ((v & mask) >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/wb_trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
module wb_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 69
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// Circular trace of MEM/WB register writes with trigger freeze and valid/ready drain.
// Optional running signature built when WB_TRACE_SIGNATURE_EN is defined.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned DATA_W    = TRACE_DATA_W,
  parameter int unsigned REG_AW    = TRACE_REG_AW,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_W      = TRACE_TS_W,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_we,
  input  logic [REG_AW-1:0]          cap_reg,
  input  logic [DATA_W-1:0]          cap_data,
  input  logic [DATA_W-1:0]          cap_pc,
  input  logic                       arm,
  input  logic                       wrap_mode,
  input  logic                       trig_en,
  input  logic [REG_AW-1:0]          trig_reg,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [REG_AW-1:0]          rd_reg,
  output logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       frozen,
  output logic [7:0]                 ovf_cnt,
  output logic [DATA_W-1:0]          signature
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = REG_AW + 2 * DATA_W + TS_W;

  trace_state_e      state_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, post_q;
  logic [7:0]        ovf_q;
  logic [TS_W-1:0]   ts_q;

  logic              qual, capturing, is_full, pop, drop, push, ovw, trig_hit;
  logic [ENTRY_W-1:0] wdata, rdata;

  always_comb begin
    qual      = cap_we && (cap_reg != '0);
    capturing = (state_q == CAPTURE) || (state_q == POST);
    is_full   = (count_q == CNT_W'(DEPTH));
    pop       = (count_q != '0) && rd_ready;
    drop      = capturing && qual && is_full && !wrap_mode;
    push      = capturing && qual && !drop;
    ovw       = push && is_full;
    trig_hit  = trig_en && (cap_reg == trig_reg);
  end

  assign wdata = {cap_reg, cap_data, cap_pc, ts_q};

  wb_trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push && !arm),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      ovf_q    <= '0;
      ts_q     <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (arm) begin
        state_q  <= CAPTURE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        post_q   <= '0;
        ovf_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        // Overwrite and pop both retire the oldest slot, so together they advance by one.
        if (ovw || pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop && !is_full) count_q <= count_q + 1'b1;
        else if (pop && !push)        count_q <= count_q - 1'b1;
        if (ovw && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 1'b1;

        unique case (state_q)
          CAPTURE: begin
            if (drop) state_q <= FROZEN;
            else if (push && trig_hit) begin
              state_q <= POST;
              post_q  <= CNT_W'(POST_TRIG);
            end
          end
          POST: begin
            if (drop) state_q <= FROZEN;
            else if (push) begin
              post_q <= post_q - 1'b1;
              if (post_q == CNT_W'(1)) state_q <= FROZEN;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

`ifdef WB_TRACE_SIGNATURE_EN
  logic [DATA_W-1:0] sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sig_q <= '0;
    else if (arm)  sig_q <= '0;
    else if (push) sig_q <= DATA_W'(rotl1(64'(sig_q), DATA_W)) ^ cap_data
                            ^ {cap_reg, {(DATA_W - REG_AW){1'b0}}};
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

  assign rd_valid = (count_q != '0);
  assign {rd_reg, rd_data, rd_pc, rd_ts} = rdata;
  assign count   = count_q;
  assign full    = is_full;
  assign empty   = (count_q == '0);
  assign frozen  = (state_q == FROZEN);
  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (default parameters).
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_we = 1'b0;
  logic [4:0]  cap_reg = '0;
  logic [31:0] cap_data = '0;
  logic [31:0] cap_pc = '0;
  logic        arm = 1'b0;
  logic        wrap_mode = 1'b0;
  logic        trig_en = 1'b0;
  logic [4:0]  trig_reg = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data, rd_pc;
  logic [15:0] rd_ts;
  logic [4:0]  count;
  logic        full, empty, frozen;
  logic [7:0]  ovf_cnt;
  logic [31:0] signature;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  wb_trace_buffer #(
    .DATA_W    (32),
    .REG_AW    (5),
    .DEPTH     (16),
    .TS_W      (16),
    .POST_TRIG (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_we    (cap_we),
    .cap_reg   (cap_reg),
    .cap_data  (cap_data),
    .cap_pc    (cap_pc),
    .arm       (arm),
    .wrap_mode (wrap_mode),
    .trig_en   (trig_en),
    .trig_reg  (trig_reg),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .rd_pc     (rd_pc),
    .rd_ts     (rd_ts),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .frozen    (frozen),
    .ovf_cnt   (ovf_cnt),
    .signature (signature)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    cap_we = 1'b1; cap_reg = r; cap_data = d; cap_pc = pc;
    cyc();
    cap_we = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, "_reg"}, 64'(rd_reg), 64'(r));
    chk({tag, "_data"}, 64'(rd_data), 64'(d));
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
  endtask

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [4:0] r,
                                           input logic [31:0] d);
    return {s[30:0], s[31]} ^ d ^ {r, 27'd0};
  endfunction

  initial begin
    trace_entry_t exp_e;
    logic [31:0]  exp_sig;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    chk("rst_sig", 64'(signature), 64'd0);

    // Basic capture, r0 filtered
    wrap_mode = 1'b1;
    do_arm();
    cap(5'd1, 32'h11, 32'h1000);
    cap(5'd2, 32'h22, 32'h1004);
    cap(5'd0, 32'h99, 32'h1008);
    chk("basic_count", 64'(count), 64'd2);
    exp_e = '{rgi: 5'd1, data: 32'h11, pc: 32'h1000, ts: 16'h0};
    chk("basic_pc0", 64'(rd_pc), 64'(exp_e.pc));
    pop_chk("basic_e0", exp_e.rgi, exp_e.data);
    chk("basic_pc1", 64'(rd_pc), 64'h1004);
    pop_chk("basic_e1", 5'd2, 32'h22);
    chk("basic_empty", 64'(empty), 64'd1);
    chk("basic_valid", 64'(rd_valid), 64'd0);

    // arm beats a same-cycle capture
    cap(5'd3, 32'h33, 32'h0);
    arm = 1'b1; cap_we = 1'b1; cap_reg = 5'd4; cap_data = 32'h44;
    cyc();
    arm = 1'b0; cap_we = 1'b0;
    chk("armprio_count", 64'(count), 64'd0);

    // Wrap mode overflow
    wrap_mode = 1'b1;
    do_arm();
    for (int i = 1; i <= 20; i++) cap(5'd1, 32'(i), 32'(4 * i));
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_ovf", 64'(ovf_cnt), 64'd4);
    chk("wrap_full", 64'(full), 64'd1);
    chk("wrap_frozen", 64'(frozen), 64'd0);
    for (int i = 5; i <= 20; i++) pop_chk("wrap_rd", 5'd1, 32'(i));
    chk("wrap_empty", 64'(empty), 64'd1);

    // Stop mode freezes when full
    wrap_mode = 1'b0;
    do_arm();
    for (int i = 1; i <= 20; i++) cap(5'd1, 32'(i), 32'(4 * i));
    chk("stop_count", 64'(count), 64'd16);
    chk("stop_frozen", 64'(frozen), 64'd1);
    chk("stop_ovf", 64'(ovf_cnt), 64'd0);
    for (int i = 1; i <= 16; i++) pop_chk("stop_rd", 5'd1, 32'(i));
    chk("stop_empty", 64'(empty), 64'd1);

    // Trigger on r7 at capture 10, freeze 4 captures later
    wrap_mode = 1'b1; trig_en = 1'b1; trig_reg = 5'd7;
    do_arm();
    chk("trig_unfrozen_after_arm", 64'(frozen), 64'd0);
    for (int i = 1; i <= 30; i++) begin
      cap((i == 10) ? 5'd7 : 5'd1, 32'(i), 32'(4 * i));
      if (i == 13) chk("trig_not_yet", 64'(frozen), 64'd0);
      if (i == 14) chk("trig_frozen", 64'(frozen), 64'd1);
    end
    chk("trig_count", 64'(count), 64'd14);
    for (int i = 1; i <= 14; i++) pop_chk("trig_rd", (i == 10) ? 5'd7 : 5'd1, 32'(i));
    chk("trig_empty", 64'(empty), 64'd1);
    trig_en = 1'b0;

    // Full wrap with simultaneous push and pop
    do_arm();
    for (int i = 1; i <= 16; i++) cap(5'd2, 32'(i), 32'(4 * i));
    chk("pp_count0", 64'(count), 64'd16);
    chk("pp_ovf0", 64'(ovf_cnt), 64'd0);
    chk("pp_head_oldest", 64'(rd_data), 64'd1);
    rd_ready = 1'b1;
    cap(5'd2, 32'd17, 32'd68);
    rd_ready = 1'b0;
    chk("pp_count1", 64'(count), 64'd16);
    chk("pp_ovf1", 64'(ovf_cnt), 64'd1);
    for (int i = 2; i <= 17; i++) pop_chk("pp_rd", 5'd2, 32'(i));
    chk("pp_empty", 64'(empty), 64'd1);

    // Async reset mid-capture
    do_arm();
    for (int i = 1; i <= 5; i++) cap(5'd5, 32'(i), 32'(4 * i));
    chk("mrst_count5", 64'(count), 64'd5);
    rst = 1'b1;
    #1;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_valid", 64'(rd_valid), 64'd0);
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) cap(5'd5, 32'(i), 32'(4 * i));
    chk("mrst_idle_count", 64'(count), 64'd0);
    chk("mrst_idle_frozen", 64'(frozen), 64'd0);
    do_arm();
    cap(5'd6, 32'h66, 32'h0);
    chk("mrst_rearm_count", 64'(count), 64'd1);
    pop_chk("mrst_rd", 5'd6, 32'h66);

    // Signature
    do_arm();
    chk("sig_clear", 64'(signature), 64'd0);
    cap(5'd3, 32'h1, 32'h0);
    cap(5'd4, 32'h2, 32'h0);
`ifdef WB_TRACE_SIGNATURE_EN
    exp_sig = sig_step(sig_step(32'h0, 5'd3, 32'h1), 5'd4, 32'h2);
`else
    exp_sig = 32'h0;
`endif
    chk("sig_value", 64'(signature), 64'(exp_sig));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
